// File: rtl/matmul_pkg.sv
// Shared types and operand-bank layout constants for the 4x4 complex matmul sequencer.
package matmul_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_e;

    localparam int N_DIM       = 4;
    localparam int A_BASE      = 0;
    localparam int B_BASE      = 32;
    localparam int ROW_STRIDE  = 8;
    localparam int CPLX_STRIDE = 2;

endpackage

// File: rtl/matmul_idx_gen.sv
// Maps element/term counters (i, j, k) to operand-bank indices and the result address.
module matmul_idx_gen
    import matmul_pkg::*;
(
    input  logic [1:0] i_row,
    input  logic [1:0] i_col,
    input  logic [1:0] i_k,
    output logic [5:0] o_a_idx,
    output logic [5:0] o_b_idx,
    output logic [3:0] o_addr
);

    // Each complex word occupies two consecutive slots (real, imag), hence the x2 strides.
    always_comb begin
        o_a_idx = 6'(A_BASE + ROW_STRIDE * int'(i_row) + CPLX_STRIDE * int'(i_k));
        o_b_idx = 6'(B_BASE + ROW_STRIDE * int'(i_k) + CPLX_STRIDE * int'(i_col));
        o_addr  = 4'(N_DIM * int'(i_row) + int'(i_col));
    end

endmodule

// File: rtl/matmul_sequencer.sv
// Walks all 16 C(i,j) elements through one shared complex MAC and strobes result writes.
// Optional `MATMUL_SEQ_CYCLE_COUNT_EN adds a 16-bit busy-cycle counter output.
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int MAC_LATENCY = 2
) (
    input  logic        CLK,
    input  logic        MasterReset,
    input  logic        Start,
    output logic [5:0]  ARegIdx,
    output logic [5:0]  BRegIdx,
    output logic        MacEnable,
    output logic        MacClear,
    output logic        ResultWrite,
    output logic [3:0]  ResultAddr,
    output logic        Busy,
`ifdef MATMUL_SEQ_CYCLE_COUNT_EN
    output logic        Done,
    output logic [15:0] CycleCount
`else
    output logic        Done
`endif
);

    state_e     r_state;
    state_e     w_next_state;
    logic [1:0] r_i;
    logic [1:0] r_j;
    logic [1:0] r_k;
    logic [2:0] r_d;
    logic       r_start_q;
    logic       r_armed;
    logic       w_start_rise;
    logic [5:0] w_a_idx;
    logic [5:0] w_b_idx;
    logic [3:0] w_addr;

    // A Start level still high when reset releases must not count as an edge,
    // so an edge is only honoured once Start has been seen low after reset.
    assign w_start_rise = Start && !r_start_q && r_armed;

    always_ff @(posedge CLK or posedge MasterReset) begin
        if (MasterReset) begin
            r_start_q <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            r_start_q <= Start;
            if (!Start) r_armed <= 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge MasterReset) begin
        if (MasterReset) r_state <= S_IDLE;
        else             r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_start_rise) w_next_state = S_ACCUM;
            S_ACCUM: if (r_k == 2'(N_DIM - 1)) w_next_state = S_DRAIN;
            S_DRAIN: if (r_d == 3'(MAC_LATENCY - 1)) w_next_state = S_WRITE;
            S_WRITE: begin
                if (r_i == 2'(N_DIM - 1) && r_j == 2'(N_DIM - 1)) w_next_state = S_DONE;
                else                                              w_next_state = S_ACCUM;
            end
            S_DONE:  if (!Start) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge MasterReset) begin
        if (MasterReset) begin
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
            r_d <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_rise) begin
                        r_i <= '0;
                        r_j <= '0;
                        r_k <= '0;
                    end
                end
                S_ACCUM: begin
                    r_k <= r_k + 2'd1;
                    if (r_k == 2'(N_DIM - 1)) r_d <= '0;
                end
                S_DRAIN: r_d <= r_d + 3'd1;
                S_WRITE: begin
                    r_k <= '0;
                    r_j <= r_j + 2'd1;
                    if (r_j == 2'(N_DIM - 1)) r_i <= r_i + 2'd1;
                end
                default: ;
            endcase
        end
    end

    matmul_idx_gen u_idx_gen (
        .i_row   (r_i),
        .i_col   (r_j),
        .i_k     (r_k),
        .o_a_idx (w_a_idx),
        .o_b_idx (w_b_idx),
        .o_addr  (w_addr)
    );

    // Outputs decode registered state only; indices read zero outside their active state.
    always_comb begin
        MacEnable   = (r_state == S_ACCUM);
        MacClear    = (r_state == S_ACCUM) && (r_k == 2'd0);
        ARegIdx     = (r_state == S_ACCUM) ? w_a_idx : 6'd0;
        BRegIdx     = (r_state == S_ACCUM) ? w_b_idx : 6'd0;
        ResultWrite = (r_state == S_WRITE);
        ResultAddr  = (r_state == S_WRITE) ? w_addr : 4'd0;
        Busy        = (r_state == S_ACCUM) || (r_state == S_DRAIN) || (r_state == S_WRITE);
        Done        = (r_state == S_DONE);
    end

`ifdef MATMUL_SEQ_CYCLE_COUNT_EN
    logic [15:0] r_cycle_count;

    always_ff @(posedge CLK or posedge MasterReset) begin
        if (MasterReset)                             r_cycle_count <= '0;
        else if (r_state == S_IDLE && w_start_rise)  r_cycle_count <= '0;
        else if (Busy)                               r_cycle_count <= r_cycle_count + 16'd1;
    end

    assign CycleCount = r_cycle_count;
`endif

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench for matmul_sequencer: default latency plus latency 1 and 7 instances.
module tb_matmul_sequencer;

    logic       CLK = 1'b0;
    logic       MasterReset = 1'b1;
    logic       Start = 1'b0;
    logic       Start1 = 1'b0;
    logic       Start7 = 1'b0;

    logic [5:0] a_idx, b_idx;
    logic       mac_en, mac_clr, res_wr, busy, done;
    logic [3:0] res_addr;

    logic [5:0] l1_a, l1_b, l7_a, l7_b;
    logic       l1_mac, l1_clr, l1_wr, l1_busy, l1_done;
    logic       l7_mac, l7_clr, l7_wr, l7_busy, l7_done;
    logic [3:0] l1_addr, l7_addr;

`ifdef MATMUL_SEQ_CYCLE_COUNT_EN
    logic [15:0] cyc_cnt, l1_cc, l7_cc;
`endif

    int errors = 0;
    int checks = 0;
    int sb_q[$];

    always #5 CLK = ~CLK;

    matmul_sequencer #(.MAC_LATENCY(2)) dut (
        .CLK(CLK), .MasterReset(MasterReset), .Start(Start),
        .ARegIdx(a_idx), .BRegIdx(b_idx), .MacEnable(mac_en), .MacClear(mac_clr),
        .ResultWrite(res_wr), .ResultAddr(res_addr), .Busy(busy),
`ifdef MATMUL_SEQ_CYCLE_COUNT_EN
        .Done(done), .CycleCount(cyc_cnt)
`else
        .Done(done)
`endif
    );

    matmul_sequencer #(.MAC_LATENCY(1)) dut_l1 (
        .CLK(CLK), .MasterReset(MasterReset), .Start(Start1),
        .ARegIdx(l1_a), .BRegIdx(l1_b), .MacEnable(l1_mac), .MacClear(l1_clr),
        .ResultWrite(l1_wr), .ResultAddr(l1_addr), .Busy(l1_busy),
`ifdef MATMUL_SEQ_CYCLE_COUNT_EN
        .Done(l1_done), .CycleCount(l1_cc)
`else
        .Done(l1_done)
`endif
    );

    matmul_sequencer #(.MAC_LATENCY(7)) dut_l7 (
        .CLK(CLK), .MasterReset(MasterReset), .Start(Start7),
        .ARegIdx(l7_a), .BRegIdx(l7_b), .MacEnable(l7_mac), .MacClear(l7_clr),
        .ResultWrite(l7_wr), .ResultAddr(l7_addr), .Busy(l7_busy),
`ifdef MATMUL_SEQ_CYCLE_COUNT_EN
        .Done(l7_done), .CycleCount(l7_cc)
`else
        .Done(l7_done)
`endif
    );

    task automatic test_reset();
        MasterReset = 1'b1;
        Start = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if ({a_idx, b_idx, mac_en, mac_clr, res_wr, res_addr, busy, done} !== 21'd0) begin
            errors++;
            $display("FAIL reset_outputs got a=%0d b=%0d mac=%b clr=%b wr=%b addr=%0d busy=%b done=%b exp all 0",
                     a_idx, b_idx, mac_en, mac_clr, res_wr, res_addr, busy, done);
        end
`ifdef MATMUL_SEQ_CYCLE_COUNT_EN
        checks++;
        if (cyc_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_cycle_count got %0d exp 0", cyc_cnt);
        end
`endif
        MasterReset = 1'b0;
    endtask

    // One full default-latency run; Start is dropped during cycle drop_at after the edge.
    task automatic observe_run(input int drop_at);
        int  wr_cnt;
        int  last, done_end;
        int  e, p, ri, rj, exp_addr;
        bit  exp_busy, exp_mac, exp_clr, exp_wr, exp_done;
        wr_cnt   = 0;
        done_end = (drop_at > 113) ? drop_at : 113;
        last     = done_end + 2;
        for (int a = 0; a < 16; a++) sb_q.push_back(a);
        @(posedge CLK); #1;
        Start = 1'b1;
        for (int cyc = 1; cyc <= last; cyc++) begin
            @(posedge CLK); #1;
            e  = (cyc - 1) / 7;
            p  = (cyc - 1) % 7;
            ri = e / 4;
            rj = e % 4;
            exp_busy = (cyc <= 112);
            exp_mac  = exp_busy && (p < 4);
            exp_clr  = exp_busy && (p == 0);
            exp_wr   = exp_busy && (p == 6);
            exp_done = (cyc >= 113) && (cyc <= done_end);
            checks++;
            if ({mac_en, mac_clr, res_wr, busy, done} !== {exp_mac, exp_clr, exp_wr, exp_busy, exp_done}) begin
                errors++;
                $display("FAIL ctrl cyc=%0d got mac=%b clr=%b wr=%b busy=%b done=%b exp mac=%b clr=%b wr=%b busy=%b done=%b",
                         cyc, mac_en, mac_clr, res_wr, busy, done, exp_mac, exp_clr, exp_wr, exp_busy, exp_done);
            end
            if (exp_mac) begin
                checks++;
                if (a_idx !== 6'(8 * ri + 2 * p) || b_idx !== 6'(32 + 8 * p + 2 * rj)) begin
                    errors++;
                    $display("FAIL operand_idx cyc=%0d got a=%0d b=%0d exp a=%0d b=%0d",
                             cyc, a_idx, b_idx, 8 * ri + 2 * p, 32 + 8 * p + 2 * rj);
                end
            end
            if (res_wr === 1'b1) begin
                wr_cnt++;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL result_addr cyc=%0d got extra write addr=%0d exp none", cyc, res_addr);
                end else begin
                    exp_addr = sb_q.pop_front();
                    if (res_addr !== 4'(exp_addr)) begin
                        errors++;
                        $display("FAIL result_addr cyc=%0d got %0d exp %0d", cyc, res_addr, exp_addr);
                    end
                end
            end
`ifdef MATMUL_SEQ_CYCLE_COUNT_EN
            if (cyc == 1 || cyc == 113) begin
                checks++;
                if (cyc_cnt !== ((cyc == 1) ? 16'd0 : 16'd112)) begin
                    errors++;
                    $display("FAIL cycle_count cyc=%0d got %0d exp %0d", cyc, cyc_cnt, (cyc == 1) ? 0 : 112);
                end
            end
`endif
            if (cyc == drop_at) Start = 1'b0;
        end
        checks++;
        if (wr_cnt != 16 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL write_count got %0d writes (%0d pending) exp 16", wr_cnt, sb_q.size());
        end
        sb_q.delete();
    endtask

    task automatic test_full_run();
        observe_run(30);
    endtask

    task automatic test_done_hold();
        observe_run(117);
    endtask

    task automatic test_back_to_back();
        observe_run(117);
        observe_run(4);
    endtask

    task automatic test_midrun_reset();
        int wr_cnt;
        wr_cnt = 0;
        @(posedge CLK); #1;
        Start = 1'b1;
        for (int cyc = 1; cyc <= 54; cyc++) begin
            @(posedge CLK); #1;
            if (res_wr === 1'b1) wr_cnt++;
        end
        // Cycle 54 is the first DRAIN cycle of element 7.
        checks++;
        if (busy !== 1'b1 || mac_en !== 1'b0 || wr_cnt != 7) begin
            errors++;
            $display("FAIL pre_reset_drain got busy=%b mac=%b writes=%0d exp busy=1 mac=0 writes=7", busy, mac_en, wr_cnt);
        end
        MasterReset = 1'b1;
        #1;
        checks++;
        if ({a_idx, b_idx, mac_en, mac_clr, res_wr, res_addr, busy, done} !== 21'd0) begin
            errors++;
            $display("FAIL midrun_reset_outputs got a=%0d b=%0d mac=%b clr=%b wr=%b addr=%0d busy=%b done=%b exp all 0",
                     a_idx, b_idx, mac_en, mac_clr, res_wr, res_addr, busy, done);
        end
        @(posedge CLK); #1;
        MasterReset = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(posedge CLK); #1;
            checks++;
            if (busy !== 1'b0 || mac_en !== 1'b0 || res_wr !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL no_restart cyc=%0d got busy=%b mac=%b wr=%b done=%b exp all 0", cyc, busy, mac_en, res_wr, done);
            end
        end
        Start = 1'b0;
        @(posedge CLK); #1;
        observe_run(5);
    endtask

    task automatic test_latency();
        int q1[$], q7[$];
        int n1, n7, b1, b7, d1, d7, exp_cyc;
        n1 = 0; n7 = 0; b1 = 0; b7 = 0; d1 = -1; d7 = -1;
        for (int k = 1; k <= 16; k++) begin
            q1.push_back(k * 6);
            q7.push_back(k * 12);
        end
        @(posedge CLK); #1;
        Start1 = 1'b1;
        Start7 = 1'b1;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(posedge CLK); #1;
            if (l1_wr === 1'b1) begin
                n1++;
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL lat1_write_time got extra write at cyc=%0d exp none", cyc);
                end else begin
                    exp_cyc = q1.pop_front();
                    if (cyc != exp_cyc) begin
                        errors++;
                        $display("FAIL lat1_write_time got cyc=%0d exp %0d", cyc, exp_cyc);
                    end
                end
            end
            if (l7_wr === 1'b1) begin
                n7++;
                checks++;
                if (q7.size() == 0) begin
                    errors++;
                    $display("FAIL lat7_write_time got extra write at cyc=%0d exp none", cyc);
                end else begin
                    exp_cyc = q7.pop_front();
                    if (cyc != exp_cyc) begin
                        errors++;
                        $display("FAIL lat7_write_time got cyc=%0d exp %0d", cyc, exp_cyc);
                    end
                end
            end
            if (l1_busy === 1'b1) b1++;
            if (l7_busy === 1'b1) b7++;
            if (l1_done === 1'b1 && d1 < 0) d1 = cyc;
            if (l7_done === 1'b1 && d7 < 0) d7 = cyc;
            if (cyc == 3) begin
                Start1 = 1'b0;
                Start7 = 1'b0;
            end
        end
        checks++;
        if (n1 != 16 || b1 != 96 || d1 != 97) begin
            errors++;
            $display("FAIL lat1_totals got writes=%0d busy=%0d done_at=%0d exp 16 96 97", n1, b1, d1);
        end
        checks++;
        if (n7 != 16 || b7 != 192 || d7 != 193) begin
            errors++;
            $display("FAIL lat7_totals got writes=%0d busy=%0d done_at=%0d exp 16 192 193", n7, b7, d7);
        end
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_done_hold();
        test_back_to_back();
        test_midrun_reset();
        test_latency();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
